da_frame_sequencer: RTL

- Single-clock sequencer for the bit-serial distributed-arithmetic LMS filter datapath.
- Replaces the separate bit clock / sample clock pair with one clock plus per-frame strobes.
- Accepts one input sample and one desired sample per frame over a valid/ready handshake.
- Drives the bit index, tap-load, accumulator clear/capture and weight-update enables, and flags the result valid.

---
 rtl/da_frame_sequencer_pkg.sv | 24 ++
 rtl/da_bit_counter.sv | 35 +++
 rtl/da_frame_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/da_frame_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// da_frame_sequencer_pkg: state encoding and default widths shared by the
// DA LMS sequencer, DA accumulator and weight blocks.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package da_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_UPDATE  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int DA_NBITS = 8;
  localparam int DA_XW    = 8;
  localparam int DA_DW    = 10;

endpackage

`default_nettype wire

// File: rtl/da_bit_counter.sv
// ---------------------------------------------------------------------------
// da_bit_counter: wrapping 0..COUNT-1 counter with enable, synchronous clear
// and a terminal-count flag.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module da_bit_counter #(
  parameter int COUNT = 8,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         r,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(COUNT - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/da_frame_sequencer.sv
// ---------------------------------------------------------------------------
// da_frame_sequencer: single-clock frame sequencer for the bit-serial DA LMS
// filter; handshakes one sample per frame and strobes the datapath.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module da_frame_sequencer
  import da_frame_sequencer_pkg::*;
#(
  parameter int NBITS       = DA_NBITS,
  parameter int TW          = 3,
  parameter int XW          = DA_XW,
  parameter int DW          = DA_DW,
  parameter int UPD_CYC     = 2,
  parameter int TRAIN_LIMIT = 0,
  parameter int FCW         = 16
) (
  input  logic           clk,
  input  logic           r,
  input  logic           x_valid,
  output logic           x_ready,
  input  logic [XW-1:0]  x_in,
  input  logic [DW-1:0]  d_in,
  input  logic           adapt_en,
  output logic [XW-1:0]  x_out,
  output logic [DW-1:0]  d_out,
  output logic [TW-1:0]  t,
  output logic           x_load,
  output logic           acc_clr,
  output logic           bit_en,
  output logic           acc_cap,
  output logic           upd_en,
  output logic           y_valid,
  output logic           busy,
  output logic [FCW-1:0] frame_cnt
);

  localparam logic [31:0] LIM = 32'(TRAIN_LIMIT);

  state_t      state;
  state_t      state_nx;
  logic        accept;
  logic        t_tc;
  logic        upd_tc;
  logic        upd_ok;
  logic        upd_ok_q;
  logic [3:0]  unused_upd_cnt;
  logic [31:0] train_cnt;

  assign x_ready = r & ((state == ST_IDLE) | (state == ST_DONE));
  assign accept  = x_valid & x_ready;
  assign upd_ok  = adapt_en & ((LIM == 32'd0) | (train_cnt < LIM));

  // Bit index wraps to 0 on its last RUN cycle, so t is 0 everywhere else.
  da_bit_counter #(.COUNT(NBITS), .W(TW)) u_bit_cnt (
    .clk (clk),
    .r   (r),
    .en  (state == ST_RUN),
    .clr (state != ST_RUN),
    .cnt (t),
    .tc  (t_tc)
  );

  da_bit_counter #(.COUNT(UPD_CYC), .W(4)) u_upd_cnt (
    .clk (clk),
    .r   (r),
    .en  (state == ST_UPDATE),
    .clr (state != ST_UPDATE),
    .cnt (unused_upd_cnt),
    .tc  (upd_tc)
  );

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    x_load   = 1'b0;
    acc_clr  = 1'b0;
    bit_en   = 1'b0;
    acc_cap  = 1'b0;
    upd_en   = 1'b0;
    y_valid  = 1'b0;
    busy     = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (accept) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        x_load   = 1'b1;
        acc_clr  = 1'b1;
        state_nx = ST_RUN;
      end
      ST_RUN: begin
        bit_en = 1'b1;
        if (t_tc) state_nx = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        acc_cap  = 1'b1;
        state_nx = upd_ok ? ST_UPDATE : ST_DONE;
      end
      ST_UPDATE: begin
        upd_en = 1'b1;
        if (upd_tc) state_nx = ST_DONE;
      end
      ST_DONE: begin
        y_valid  = 1'b1;
        state_nx = accept ? ST_LOAD : ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      x_out     <= '0;
      d_out     <= '0;
      frame_cnt <= '0;
      train_cnt <= '0;
      upd_ok_q  <= 1'b0;
    end else begin
      if (accept) begin
        x_out <= x_in;
        d_out <= d_in;
      end
      if (state == ST_CAPTURE) begin
        upd_ok_q <= upd_ok;
      end
      // Train count saturates at the limit; with no limit it simply stays 0.
      if ((state == ST_UPDATE) && upd_tc && upd_ok_q && (train_cnt != LIM)) begin
        train_cnt <= train_cnt + 32'd1;
      end
      if ((state == ST_DONE) && (frame_cnt != '1)) begin
        frame_cnt <= frame_cnt + FCW'(1);
      end
    end
  end

endmodule

`default_nettype wire
